// File: rtl/retire_trace_unit.sv
// rtl/retire_trace_unit.sv - retirement counter, trace FIFO and halt control for sccomp
// Optional build macro TRACE_ALL_EN: trace every accepted retirement, not only register writes.
module retire_trace_unit #(
  parameter int unsigned STOP_INSTR  = 200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] ECALL_INSTR = 32'h00000073
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run_en,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_instr,
  input  logic        ret_rd_we,
  input  logic [4:0]  ret_rd,
  input  logic [31:0] ret_rd_wdata,
  output logic        cpu_stall,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_data,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [31:0]   LAST_INSTR = 32'(STOP_INSTR - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t        state;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [4:0]    rd_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];

  logic        accept, push, pop, is_ecall, is_budget, rd_written;
  logic [4:0]  push_rd;
  logic [31:0] push_data;

  assign cpu_stall   = (state != RUN) || (count == FULL_CNT);
  assign accept      = ret_valid && !cpu_stall;
  assign trace_valid = (count != '0);
  assign pop         = trace_valid && trace_ready;
  assign is_ecall    = (ret_instr == ECALL_INSTR);
  assign is_budget   = (instr_count == LAST_INSTR);
  assign rd_written  = ret_rd_we && (ret_rd != 5'd0);

`ifdef TRACE_ALL_EN
  // Non-writing entries carry the encoding so the consumer can still identify them.
  assign push      = accept;
  assign push_rd   = rd_written ? ret_rd : 5'd0;
  assign push_data = rd_written ? ret_rd_wdata : ret_instr;
`else
  assign push      = accept && rd_written;
  assign push_rd   = ret_rd;
  assign push_data = ret_rd_wdata;
`endif

  assign trace_pc   = pc_mem[rd_ptr];
  assign trace_rd   = rd_mem[rd_ptr];
  assign trace_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= ret_pc;
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
      halt_cause  <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase

      case (state)
        IDLE: if (run_en) state <= RUN;
        RUN: begin
          if (accept) begin
            instr_count <= instr_count + 32'd1;
            // The halting instruction is still counted and traced.
            if (is_ecall || is_budget) begin
              state      <= DRAIN;
              halt_cause <= {is_budget, is_ecall};
            end
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_unit.sv
// tb/tb_retire_trace_unit.sv - scoreboard bench for retire_trace_unit (directed plan + random)
module tb_retire_trace_unit;

  localparam int          STOP  = 12;
  localparam int          DEPTH = 8;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic        clk = 1'b0, rstn = 1'b0, run_en = 1'b0, ret_valid = 1'b0;
  logic        ret_rd_we = 1'b0, trace_ready = 1'b0;
  logic [31:0] ret_pc = '0, ret_instr = '0, ret_rd_wdata = '0;
  logic [4:0]  ret_rd = '0;
  logic        cpu_stall, trace_valid, halted;
  logic [31:0] trace_pc, trace_data, instr_count;
  logic [4:0]  trace_rd;
  logic [1:0]  halt_cause;

  always #5 clk = ~clk;

  retire_trace_unit #(.STOP_INSTR(STOP), .FIFO_DEPTH(DEPTH), .ECALL_INSTR(ECALL)) dut (
    .clk(clk), .rstn(rstn), .run_en(run_en), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_wdata(ret_rd_wdata),
    .cpu_stall(cpu_stall), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_data(trace_data),
    .instr_count(instr_count), .halted(halted), .halt_cause(halt_cause)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      mon_e, new_e;
  int          n_asserts = 0, n_fail = 0, n_pops = 0;
  int          m_phase = 0, m_occ = 0, m_next;
  logic [31:0] m_cnt = '0, pc_ctr = 32'h100;
  logic [1:0]  m_cause = '0;
  bit          m_valid = 0, m_accepted = 0, m_stall, m_pop, m_push, m_e, m_b, m_wr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phases 0 idle, 1 run, 2 drain, 3 halt; occupancy tracked as a plain count.
  always @(posedge clk) begin
    m_accepted = 0;
    if (!rstn) begin
      m_phase = 0; m_occ = 0; m_cnt = '0; m_cause = '0;
      exp_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      m_stall = (m_phase != 1) || (m_occ == DEPTH);
      m_pop   = (m_occ > 0) && trace_ready;
      m_push  = 0;
      m_next  = m_phase;
      case (m_phase)
        0: if (run_en) m_next = 1;
        1: if (ret_valid && !m_stall) begin
             m_accepted = 1;
             m_e  = (ret_instr == ECALL);
             m_b  = (m_cnt == STOP - 1);
             m_cnt = m_cnt + 1;
             m_wr = ret_rd_we && (ret_rd != 0);
`ifdef TRACE_ALL_EN
             m_push = 1;
             new_e  = '{ret_pc, m_wr ? ret_rd : 5'd0, m_wr ? ret_rd_wdata : ret_instr};
`else
             m_push = m_wr;
             new_e  = '{ret_pc, ret_rd, ret_rd_wdata};
`endif
             if (m_push) exp_q.push_back(new_e);
             if (m_e || m_b) begin
               m_next  = 2;
               m_cause = {m_b, m_e};
             end
           end
        2: if (m_occ == 0) m_next = 3;
        default: ;
      endcase
      m_occ   = m_occ + int'(m_push) - int'(m_pop);
      m_phase = m_next;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cpu_stall", 32'(cpu_stall), 32'((m_phase != 1) || (m_occ == DEPTH)));
      check("trace_valid", 32'(trace_valid), 32'(m_occ > 0));
      check("instr_count", instr_count, m_cnt);
      check("halted", 32'(halted), 32'(m_phase == 3));
      check("halt_cause", 32'(halt_cause), 32'(m_cause));
    end
  end

  always @(negedge clk) begin
    if (m_valid && trace_valid === 1'b1 && trace_ready) begin
      if (exp_q.size() == 0) begin
        n_asserts++;
        n_fail++;
        $display("FAIL trace_unexpected: got pc %0h with no entry expected", trace_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("trace_pc", trace_pc, mon_e.pc);
        check("trace_rd", 32'(trace_rd), 32'(mon_e.rd));
        check("trace_data", trace_data, mon_e.data);
        n_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; run_en = 1'b0; ret_valid = 1'b0; trace_ready = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic start();
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
  endtask

  task automatic retire(input logic [31:0] instr, input logic we, input logic [4:0] rd,
                        input logic [31:0] data);
    int budget = 50;
    ret_valid = 1'b1; ret_pc = pc_ctr; ret_instr = instr;
    ret_rd_we = we; ret_rd = rd; ret_rd_wdata = data;
    pc_ctr = pc_ctr + 4;
    do begin
      tick();
      budget--;
    end while (!m_accepted && budget > 0);
    if (!m_accepted) begin
      n_asserts++;
      n_fail++;
      $display("FAIL retire_timeout: got no accept expected accept of pc %0h", ret_pc);
    end
    ret_valid = 1'b0;
  endtask

  task automatic wait_halt();
    int budget = 40;
    while (halted !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  function automatic logic [31:0] plain_instr();
    logic [31:0] v = $urandom;
    return (v == ECALL) ? 32'h00000013 : v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: basic writes, x0 not traced
    do_reset(); start(); trace_ready = 1'b1;
    retire(32'h00500293, 1'b1, 5'd5, 32'd1);
    retire(32'h00600313, 1'b1, 5'd6, 32'd2);
    retire(32'h00900013, 1'b1, 5'd0, 32'd9);
    repeat (3) tick();
    check("t1_count", instr_count, 32'd3);
    check("t1_stall", 32'(cpu_stall), 32'd0);
`ifndef TRACE_ALL_EN
    check("t1_pops", 32'(n_pops), 32'd2);
`endif

    // 2: fill FIFO, 9th retirement held until one pop
    do_reset(); start();
    for (int i = 1; i <= 8; i++) retire(plain_instr(), 1'b1, 5'(i), 32'(i * 3));
    ret_valid = 1'b1; ret_rd_we = 1'b1; ret_rd = 5'd9; ret_rd_wdata = 32'd27;
    ret_pc = pc_ctr; ret_instr = 32'h00000013; pc_ctr = pc_ctr + 4;
    repeat (3) tick();
    check("t2_full_stall", 32'(cpu_stall), 32'd1);
    check("t2_held_count", instr_count, 32'd8);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    begin
      int budget = 5;
      while (!m_accepted && budget > 0) begin tick(); budget--; end
    end
    ret_valid = 1'b0;
    check("t2_count", instr_count, 32'd9);
    trace_ready = 1'b1; repeat (12) tick();

    // 3: ecall at count 4 with two entries queued
    do_reset(); start();
    retire(plain_instr(), 1'b1, 5'd1, 32'h11);
    retire(plain_instr(), 1'b1, 5'd2, 32'h22);
    retire(plain_instr(), 1'b0, 5'd3, 32'h33);
    retire(plain_instr(), 1'b1, 5'd0, 32'h44);
    trace_ready = 1'b1;
    retire(ECALL, 1'b0, 5'd0, 32'd0);
    wait_halt();
    check("t3_cause", 32'(halt_cause), 32'd1);
    check("t3_count", instr_count, 32'd5);

    // 4: budget halt, later retirements ignored
    do_reset(); start(); trace_ready = 1'b1;
    for (int i = 0; i < STOP; i++) retire(plain_instr(), 1'b1, 5'(i % 31 + 1), $urandom);
    wait_halt();
    check("t4_cause", 32'(halt_cause), 32'd2);
    ret_valid = 1'b1; run_en = 1'b1; repeat (3) tick(); ret_valid = 1'b0; run_en = 1'b0;
    check("t4_count", instr_count, 32'(STOP));

    // 5: last budgeted instruction is an ecall
    do_reset(); start(); trace_ready = 1'b1;
    for (int i = 0; i < STOP - 1; i++) retire(plain_instr(), 1'b1, 5'(i % 31 + 1), $urandom);
    retire(ECALL, 1'b0, 5'd0, 32'd0);
    wait_halt();
    check("t5_cause", 32'(halt_cause), 32'd3);

    // 6: reset with entries queued
    do_reset(); start();
    for (int i = 1; i <= 5; i++) retire(plain_instr(), 1'b1, 5'(i), $urandom);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("t6_valid", 32'(trace_valid), 32'd0);
    check("t6_count", instr_count, 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_stall", 32'(cpu_stall), 32'd1);

    // Random traffic
    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        rstn         = ($urandom_range(0, 199) != 0);
        run_en       = ($urandom_range(0, 2) == 0);
        ret_valid    = ($urandom_range(0, 9) < 7);
        ret_instr    = ($urandom_range(0, 29) == 0) ? ECALL : plain_instr();
        ret_rd_we    = ($urandom_range(0, 9) < 6);
        ret_rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        ret_rd_wdata = $urandom;
        ret_pc       = pc_ctr;
        pc_ctr       = pc_ctr + 4;
        trace_ready  = ($urandom_range(0, 1) == 1);
        tick();
      end
    end
    ret_valid = 1'b0; trace_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
